lw_sha_padder: RTL and testbench

- Upstream feeder for the lightweight SHA-256/224 core.
- Accepts a raw big-endian message as a stream of 32-bit words and applies FIPS 180-4 padding: a 0x80 marker, zero fill, and a 64-bit bit-length.
- Drives the core's start/data/last/opcode/abort inputs so the core sees back-to-back 16-word blocks.
- Throttles the message source through a valid/ready handshake.

---
 rtl/lw_sha_padder.sv | 165 ++++++++++++++++
 tb/tb_lw_sha_padder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lw_sha_padder.sv
// FIPS 180-4 message padder feeding the lightweight SHA-256/224 core.
// Streams raw message words, then appends the 0x80 marker, zero fill and 64-bit bit length.
module lw_sha_padder #(
    parameter int WORD_SIZE = 32,
    parameter int LEN_W     = 64
) (
    input  logic                 clk_i,
    input  logic                 aresetn_i,
    input  logic                 msg_valid_i,
    input  logic [WORD_SIZE-1:0] msg_data_i,
    input  logic                 msg_last_i,
    input  logic [1:0]           msg_bytes_i,
    output logic                 msg_ready_o,
    input  logic                 opcode_i,
    input  logic                 abort_i,
    input  logic                 core_ready_i,
    input  logic                 core_data_ready_i,
    output logic                 start_o,
    output logic                 opcode_o,
    output logic                 abort_o,
    output logic                 data_valid_o,
    output logic [WORD_SIZE-1:0] data_o,
    output logic                 last_o,
    output logic                 busy_o
);

    localparam int CNT_W = LEN_W - 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_MARK,
        S_ZERO,
        S_LEN_HI,
        S_LEN_LO
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic               opcode_q, opcode_d;
    logic [LEN_W-1:0]   len_bits;
    logic [WORD_SIZE-1:0] last_word;
    logic [2:0]         byte_add;
    logic               xfer;
    logic               idx_end;

    assign len_bits = {byte_cnt_q, 3'b000};
    assign idx_end  = (idx_q == 4'd13);
    assign byte_add = (msg_last_i && (msg_bytes_i != 2'd0)) ? {1'b0, msg_bytes_i} : 3'd4;

    // Final partial word: keep k leading bytes, marker in byte k, zero the rest.
    always_comb begin
        case (msg_bytes_i)
            2'd1:    last_word = {msg_data_i[31:24], 8'h80, 16'h0000};
            2'd2:    last_word = {msg_data_i[31:16], 8'h80, 8'h00};
            2'd3:    last_word = {msg_data_i[31:8], 8'h80};
            default: last_word = msg_data_i;
        endcase
    end

    // Handshakes: a message word moves when msg_valid_i && msg_ready_o, a core word moves
    // when data_valid_o && core_data_ready_i; valid is never withdrawn while waiting for ready.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        byte_cnt_d   = byte_cnt_q;
        opcode_d     = opcode_q;
        msg_ready_o  = 1'b0;
        start_o      = 1'b0;
        data_valid_o = 1'b0;
        data_o       = '0;
        last_o       = 1'b0;
        xfer         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (msg_valid_i && core_ready_i && !abort_i) begin
                    opcode_d   = opcode_i;
                    idx_d      = '0;
                    byte_cnt_d = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                start_o = 1'b1;
                state_d = S_DATA;
            end
            S_DATA: begin
                data_valid_o = msg_valid_i;
                msg_ready_o  = core_data_ready_i;
                data_o       = msg_last_i ? last_word : msg_data_i;
                xfer         = msg_valid_i && core_data_ready_i;
                if (xfer) begin
                    byte_cnt_d = byte_cnt_q + CNT_W'(byte_add);
                    if (msg_last_i) begin
                        if (msg_bytes_i == 2'd0) state_d = S_MARK;
                        else                     state_d = idx_end ? S_LEN_HI : S_ZERO;
                    end
                end
            end
            S_MARK: begin
                data_valid_o = 1'b1;
                data_o       = 32'h8000_0000;
                xfer         = core_data_ready_i;
                if (xfer) state_d = idx_end ? S_LEN_HI : S_ZERO;
            end
            S_ZERO: begin
                data_valid_o = 1'b1;
                xfer         = core_data_ready_i;
                if (xfer && idx_end) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                data_valid_o = 1'b1;
                data_o       = len_bits[LEN_W-1:WORD_SIZE];
                last_o       = 1'b1;
                xfer         = core_data_ready_i;
                if (xfer) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                data_valid_o = 1'b1;
                data_o       = len_bits[WORD_SIZE-1:0];
                last_o       = 1'b1;
                xfer         = core_data_ready_i;
                if (xfer) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (xfer) idx_d = idx_q + 4'd1;

        // Abort suppresses any transfer offered this cycle so the core never sees a half word.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            idx_d        = '0;
            byte_cnt_d   = '0;
            opcode_d     = 1'b0;
            msg_ready_o  = 1'b0;
            start_o      = 1'b0;
            data_valid_o = 1'b0;
            data_o       = '0;
            last_o       = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            opcode_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            opcode_q   <= opcode_d;
        end
    end

    assign opcode_o = opcode_q;
    assign abort_o  = abort_i;
    assign busy_o   = (state_q != S_IDLE);

endmodule

// File: tb/tb_lw_sha_padder.sv
// Bench for lw_sha_padder: a behavioural core stub consumes blocks while a byte-level
// padding model predicts every word and last flag.
`timescale 1ns/1ps
module tb_lw_sha_padder;

    logic        clk_i = 1'b0;
    logic        aresetn_i = 1'b0;
    logic        msg_valid_i = 1'b0;
    logic [31:0] msg_data_i = '0;
    logic        msg_last_i = 1'b0;
    logic [1:0]  msg_bytes_i = '0;
    logic        msg_ready_o;
    logic        opcode_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        core_ready_i = 1'b0;
    logic        core_data_ready_i = 1'b0;
    logic        start_o;
    logic        opcode_o;
    logic        abort_o;
    logic        data_valid_o;
    logic [31:0] data_o;
    logic        last_o;
    logic        busy_o;

    lw_sha_padder dut (
        .clk_i(clk_i), .aresetn_i(aresetn_i),
        .msg_valid_i(msg_valid_i), .msg_data_i(msg_data_i), .msg_last_i(msg_last_i),
        .msg_bytes_i(msg_bytes_i), .msg_ready_o(msg_ready_o), .opcode_i(opcode_i),
        .abort_i(abort_i), .core_ready_i(core_ready_i), .core_data_ready_i(core_data_ready_i),
        .start_o(start_o), .opcode_o(opcode_o), .abort_o(abort_o), .data_valid_o(data_valid_o),
        .data_o(data_o), .last_o(last_o), .busy_o(busy_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;
    int start_cnt = 0;

    always @(negedge clk_i) if (start_o) start_cnt++;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check1({tag, " msg_ready_o"}, msg_ready_o, 1'b0);
        check1({tag, " start_o"}, start_o, 1'b0);
        check1({tag, " opcode_o"}, opcode_o, 1'b0);
        check1({tag, " abort_o"}, abort_o, 1'b0);
        check1({tag, " data_valid_o"}, data_valid_o, 1'b0);
        check32({tag, " data_o"}, data_o, 32'h0);
        check1({tag, " last_o"}, last_o, 1'b0);
        check1({tag, " busy_o"}, busy_o, 1'b0);
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mb[$];
    logic [31:0] exp_q[$];
    logic        exp_last_q[$];
    logic [31:0] got_q[$];
    logic        got_last_q[$];

    task automatic build_expected();
        logic [7:0]  pb[$];
        logic [63:0] bits;
        pb = mb;
        bits = 64'(mb.size()) * 64'd8;
        pb.push_back(8'h80);
        while ((pb.size() % 64) != 56) pb.push_back(8'h00);
        for (int i = 7; i >= 0; i--) pb.push_back(bits[i*8 +: 8]);
        exp_q.delete();
        exp_last_q.delete();
        for (int i = 0; i < pb.size(); i += 4) begin
            exp_q.push_back({pb[i], pb[i+1], pb[i+2], pb[i+3]});
            exp_last_q.push_back(i >= pb.size() - 8);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_src(input logic op, input int max_gap);
        int          nw;
        int          tmo;
        logic [31:0] w;
        nw = (mb.size() + 3) / 4;
        for (int wi = 0; wi < nw; wi++) begin
            repeat ($urandom_range(0, max_gap)) begin
                msg_valid_i = 1'b0;
                @(posedge clk_i); #1;
            end
            w = $urandom();
            for (int b = 0; b < 4; b++)
                if (wi*4 + b < mb.size()) w[31-8*b -: 8] = mb[wi*4 + b];
            msg_data_i  = w;
            msg_last_i  = (wi == nw - 1);
            msg_bytes_i = (wi == nw - 1) ? 2'(mb.size() % 4) : 2'($urandom_range(0, 3));
            opcode_i    = (wi == 0) ? op : 1'($urandom_range(0, 1));
            msg_valid_i = 1'b1;
            tmo = 0;
            do begin
                @(negedge clk_i);
                tmo++;
            end while (!msg_ready_o && tmo < 2000);
            if (!msg_ready_o) begin
                check1("src_handshake_timeout", msg_ready_o, 1'b1);
                msg_valid_i = 1'b0;
                msg_last_i  = 1'b0;
                return;
            end
            @(posedge clk_i); #1;
        end
        msg_valid_i = 1'b0;
        msg_last_i  = 1'b0;
    endtask

    task automatic core_run(input logic op, input logic [15:0] stall_mask);
        int          tmo;
        int          xfers;
        int          stall_left;
        int          stalled_idx;
        bit          saw_last;
        bit          prev_hold;
        logic [31:0] prev_data;
        core_ready_i      = 1'b1;
        core_data_ready_i = 1'b0;
        tmo = 0;
        do begin
            @(negedge clk_i);
            tmo++;
        end while (!start_o && tmo < 1000);
        if (!start_o) begin
            check1("core_start_timeout", start_o, 1'b1);
            return;
        end
        check1("opcode_latched", opcode_o, op);
        check1("busy_in_start", busy_o, 1'b1);
        @(posedge clk_i); #1;
        core_ready_i = 1'b0;
        saw_last = 0;
        tmo = 0;
        while (!saw_last && tmo < 4000) begin
            xfers = 0; stall_left = 0; stalled_idx = -1; prev_hold = 0; prev_data = '0;
            while (xfers < 16 && tmo < 4000) begin
                if (stall_left > 0) begin
                    core_data_ready_i = 1'b0;
                    stall_left--;
                end else if (stall_mask[xfers] && stalled_idx != xfers) begin
                    core_data_ready_i = 1'b0;
                    stall_left  = 4;
                    stalled_idx = xfers;
                end else begin
                    core_data_ready_i = ($urandom_range(0, 3) != 0);
                end
                @(negedge clk_i);
                tmo++;
                if (prev_hold) begin
                    check1("hold_valid", data_valid_o, 1'b1);
                    check32("hold_data", data_o, prev_data);
                end
                if (data_valid_o && core_data_ready_i) begin
                    got_q.push_back(data_o);
                    got_last_q.push_back(last_o);
                    if (last_o) saw_last = 1;
                    xfers++;
                end
                prev_hold = data_valid_o && !core_data_ready_i;
                prev_data = data_o;
                @(posedge clk_i); #1;
            end
            // rounds 16-64: the core takes no schedule words
            core_data_ready_i = 1'b0;
            repeat ($urandom_range(3, 10)) begin
                @(negedge clk_i);
                check1("ready_low_in_rounds", msg_ready_o, 1'b0);
                @(posedge clk_i); #1;
            end
        end
        if (!saw_last) check1("core_last_timeout", 1'b0, 1'b1);
        core_ready_i = 1'b1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic run_msg(input string tag, input logic op, input int max_gap,
                           input logic [15:0] stall_mask);
        int s0;
        build_expected();
        got_q.delete();
        got_last_q.delete();
        s0 = start_cnt;
        fork
            send_src(op, max_gap);
            core_run(op, stall_mask);
        join
        @(negedge clk_i);
        check32({tag, " start_pulses"}, start_cnt - s0, 32'd1);
        check1({tag, " busy_after"}, busy_o, 1'b0);
        check32({tag, " word_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check32($sformatf("%s word %0d", tag, i), got_q[i], exp_q[i]);
            check1($sformatf("%s last %0d", tag, i), got_last_q[i], exp_last_q[i]);
        end
    endtask

    typedef struct {
        int          n_bytes;
        bit          abc;
        logic        op;
        logic [15:0] stall_mask;
        int          exp_words;
        logic [31:0] exp_len_lo;
        int          chk_i;
        logic [31:0] chk_v;
    } vec_t;

    vec_t tbl[7];

    task automatic start_partial(input int n_xfers);
        int tmo;
        msg_valid_i = 1'b1; msg_last_i = 1'b0; msg_data_i = $urandom(); opcode_i = 1'b1;
        core_ready_i = 1'b1; core_data_ready_i = 1'b1;
        tmo = 0;
        do begin
            @(negedge clk_i);
            tmo++;
        end while (!start_o && tmo < 50);
        check1("partial_start", start_o, 1'b1);
        @(posedge clk_i); #1;
        core_ready_i = 1'b0;
        for (int i = 0; i < n_xfers; i++) begin
            @(negedge clk_i);
            check1("partial_xfer", data_valid_o && msg_ready_o, 1'b1);
            @(posedge clk_i); #1;
            msg_data_i = $urandom();
        end
    endtask

    initial begin
        tbl[0] = '{3,   1'b1, 1'b0, 16'h4020, 16, 32'h18,  0,  32'h61626380};
        tbl[1] = '{55,  1'b0, 1'b1, 16'h0000, 16, 32'h1B8, 13, 32'hAABBCC80};
        tbl[2] = '{56,  1'b0, 1'b0, 16'h8000, 32, 32'h1C0, 14, 32'h80000000};
        tbl[3] = '{64,  1'b0, 1'b1, 16'h0001, 32, 32'h200, 16, 32'h80000000};
        tbl[4] = '{1,   1'b0, 1'b0, 16'h0000, 16, 32'h8,   0,  32'h01800000};
        tbl[5] = '{119, 1'b0, 1'b0, 16'h2000, 32, 32'h3B8, 29, 32'h75767780};
        tbl[6] = '{120, 1'b0, 1'b1, 16'h4020, 48, 32'h3C0, 30, 32'h80000000};

        repeat (3) @(posedge clk_i);
        #1;
        check_all_zero("in_reset");
        aresetn_i = 1'b1;
        @(negedge clk_i);
        check_all_zero("after_reset");

        for (int i = 0; i < 7; i++) begin
            mb.delete();
            if (tbl[i].abc) begin
                mb.push_back(8'h61); mb.push_back(8'h62); mb.push_back(8'h63);
            end else begin
                for (int b = 0; b < tbl[i].n_bytes; b++) mb.push_back(8'(b + 1));
                if (tbl[i].n_bytes == 55) begin
                    mb[52] = 8'hAA; mb[53] = 8'hBB; mb[54] = 8'hCC;
                end
            end
            run_msg($sformatf("vec%0d", i), tbl[i].op, i % 3, tbl[i].stall_mask);
            check32($sformatf("vec%0d words", i), got_q.size(), tbl[i].exp_words);
            check32($sformatf("vec%0d len_lo", i), got_q[got_q.size()-1], tbl[i].exp_len_lo);
            check32($sformatf("vec%0d len_hi", i), got_q[got_q.size()-2], 32'h0);
            check32($sformatf("vec%0d key_word", i), got_q[tbl[i].chk_i], tbl[i].chk_v);
        end

        // abort at idx 7 of a long message, then a clean "abc"
        start_partial(7);
        abort_i = 1'b1;
        @(negedge clk_i);
        check1("abort_o", abort_o, 1'b1);
        check1("abort_blocks_valid", data_valid_o, 1'b0);
        check1("abort_blocks_ready", msg_ready_o, 1'b0);
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        msg_valid_i = 1'b0;
        core_data_ready_i = 1'b0;
        @(negedge clk_i);
        check_all_zero("after_abort");
        mb.delete();
        mb.push_back(8'h61); mb.push_back(8'h62); mb.push_back(8'h63);
        run_msg("abc_after_abort", 1'b0, 0, 16'h0000);

        // asynchronous reset in the middle of a message
        start_partial(3);
        #2 aresetn_i = 1'b0;
        #1;
        check_all_zero("mid_reset");
        msg_valid_i = 1'b0;
        core_data_ready_i = 1'b0;
        @(posedge clk_i); #1;
        aresetn_i = 1'b1;

        for (int r = 0; r < 8; r++) begin
            mb.delete();
            repeat ($urandom_range(1, 200)) mb.push_back(8'($urandom()));
            run_msg($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                    16'($urandom()));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
